// File: rtl/sys_defs.sv
// Shared memory-bus definitions: bus commands, memory tags and request owners.
package sys_defs;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned NumTags = 15;

   typedef logic [3:0] MEM_TAG;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } BUS_COMMAND;

   typedef enum logic {
      ICACHE = 1'b0,
      DCACHE = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_tag_table.sv
// Outstanding-load owner table for memory tags 1..15; allocation beats a same-cycle free.
module mem_tag_table
   import sys_defs::*;
(
   input  logic   clk_i,
   input  logic   rst_ni,
   input  logic   alloc_valid_i,
   input  MEM_TAG alloc_tag_i,
   input  owner_e alloc_owner_i,
   input  logic   free_valid_i,
   input  MEM_TAG free_tag_i,
   input  MEM_TAG lookup_tag_i,
   output logic   lookup_valid_o,
   output owner_e lookup_owner_o
);

   logic [NumTags:1] valid_q, valid_d;
   owner_e           owner_q [NumTags:1];
   owner_e           owner_d [NumTags:1];

   always_comb begin
      valid_d = valid_q;
      owner_d = owner_q;
      for (int unsigned i = 1; i <= NumTags; i++) begin
         if (free_valid_i && (free_tag_i == MEM_TAG'(i))) begin
            valid_d[i] = 1'b0;
         end
         if (alloc_valid_i && (alloc_tag_i == MEM_TAG'(i))) begin
            valid_d[i] = 1'b1;
            owner_d[i] = alloc_owner_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         for (int unsigned i = 1; i <= NumTags; i++) begin
            owner_q[i] <= ICACHE;
         end
      end else begin
         valid_q <= valid_d;
         owner_q <= owner_d;
      end
   end

   // Tag 0 matches no entry, so it never reports valid.
   always_comb begin
      lookup_valid_o = 1'b0;
      lookup_owner_o = ICACHE;
      for (int unsigned i = 1; i <= NumTags; i++) begin
         if (lookup_tag_i == MEM_TAG'(i)) begin
            lookup_valid_o = valid_q[i];
            lookup_owner_o = owner_q[i];
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache/dcache requests onto one memory port and routes tagged load data back.
module mem_arbiter
   import sys_defs::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             icache_req_valid,
   input  logic [XLEN-1:0]  icache_req_addr,
   input  logic             dcache_req_valid,
   input  BUS_COMMAND       dcache_req_cmd,
   input  logic [XLEN-1:0]  dcache_req_addr,
   input  logic [63:0]      dcache_req_data,
   output logic             icache_grant,
   output logic             dcache_grant,
   output MEM_TAG           icache_resp_tag,
   output MEM_TAG           dcache_resp_tag,
   output logic             icache_data_valid,
   output logic             dcache_data_valid,
   output MEM_TAG           icache_data_tag,
   output MEM_TAG           dcache_data_tag,
   output logic [63:0]      icache_data,
   output logic [63:0]      dcache_data,
   output BUS_COMMAND       proc2mem_command,
   output logic [XLEN-1:0]  proc2mem_addr,
   output logic [63:0]      proc2mem_data,
   input  MEM_TAG           mem2proc_response,
   input  logic [63:0]      mem2proc_data,
   input  MEM_TAG           mem2proc_tag,
   output logic             stray_tag
);

   localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

   logic [CntW-1:0] starve_q, starve_d;
   logic            ic_sel, dc_sel, accept;
   logic            alloc_valid;
   logic            lookup_valid, route_hit;
   owner_e          lookup_owner;

   always_comb begin
      dc_sel = dcache_req_valid && !(icache_req_valid && (starve_q == StarveMax));
      ic_sel = icache_req_valid && !dc_sel;
      accept = reset && (mem2proc_response != '0);
   end

   always_comb begin
      proc2mem_command = BUS_NONE;
      proc2mem_addr    = '0;
      proc2mem_data    = '0;
      if (reset && dc_sel) begin
         proc2mem_command = dcache_req_cmd;
         proc2mem_addr    = dcache_req_addr;
         proc2mem_data    = dcache_req_data;
      end else if (reset && ic_sel) begin
         proc2mem_command = BUS_LOAD;
         proc2mem_addr    = icache_req_addr;
      end
   end

   always_comb begin
      icache_grant    = ic_sel && accept;
      dcache_grant    = dc_sel && accept;
      icache_resp_tag = icache_grant ? mem2proc_response : '0;
      dcache_resp_tag = dcache_grant ? mem2proc_response : '0;
      alloc_valid     = accept && (proc2mem_command == BUS_LOAD);
   end

   // Waiting icache loses only while dcache is actually granted.
   always_comb begin
      starve_d = starve_q;
      if (!icache_req_valid || icache_grant) begin
         starve_d = '0;
      end else if (dcache_grant && (starve_q != StarveMax)) begin
         starve_d = starve_q + CntW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

   mem_tag_table u_tag_table (
      .clk_i          (clock),
      .rst_ni         (reset),
      .alloc_valid_i  (alloc_valid),
      .alloc_tag_i    (mem2proc_response),
      .alloc_owner_i  (dc_sel ? DCACHE : ICACHE),
      .free_valid_i   (route_hit),
      .free_tag_i     (mem2proc_tag),
      .lookup_tag_i   (mem2proc_tag),
      .lookup_valid_o (lookup_valid),
      .lookup_owner_o (lookup_owner)
   );

   always_comb begin
      route_hit         = reset && (mem2proc_tag != '0) && lookup_valid;
      stray_tag         = reset && (mem2proc_tag != '0) && !lookup_valid;
      icache_data_valid = route_hit && (lookup_owner == ICACHE);
      dcache_data_valid = route_hit && (lookup_owner == DCACHE);
      icache_data_tag   = icache_data_valid ? mem2proc_tag  : '0;
      dcache_data_tag   = dcache_data_valid ? mem2proc_tag  : '0;
      icache_data       = icache_data_valid ? mem2proc_data : '0;
      dcache_data       = dcache_data_valid ? mem2proc_data : '0;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive dcache wins allowed while icache waits.
REQ-002 SHALL have port clock  in  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  one clock; reset is asynchronous and active-low (reset==0 resets).
REQ-004 SHALL have ports icache_req_valid in 1, icache_req_addr in XLEN: icache miss (always BUS_LOAD).
REQ-005 SHALL have ports dcache_req_valid in 1, dcache_req_cmd in BUS_COMMAND, dcache_req_addr in XLEN, dcache_req_data in 64: dcache request.
REQ-006 SHALL have outputs icache_grant, dcache_grant (1 each) and icache_resp_tag, dcache_resp_tag (4 each): accepted this cycle, with memory tag.
REQ-007 SHALL have outputs icache_data_valid, dcache_data_valid (1 each), icache_data_tag, dcache_data_tag (4 each), icache_data, dcache_data (64 each): routed load return.
REQ-008 SHALL have outputs proc2mem_command BUS_COMMAND, proc2mem_addr XLEN, proc2mem_data 64; inputs mem2proc_response 4, mem2proc_data 64, mem2proc_tag 4.
REQ-009 SHALL have output stray_tag 1: nonzero mem2proc_tag with no owner entry.

Function
REQ-010 SHALL select at most one requester per cycle and drive its command/addr/data to memory combinationally; no requester -> BUS_NONE, addr 0, data 0.
REQ-011 SHALL give dcache priority when both request, unless starve_cnt == STARVE_LIMIT, then icache wins.
REQ-012 starve_cnt SHALL increment (saturating at STARVE_LIMIT) each cycle dcache is granted while icache_req_valid; SHALL clear when icache is granted or icache_req_valid==0.
REQ-013 A request SHALL be accepted only if mem2proc_response != 0 in that cycle; winner's grant=1 and resp_tag=mem2proc_response; loser's grant=0.
REQ-014 mem2proc_response==0 SHALL give no grant and no state change except starve_cnt (counts only on actual dcache grant).
REQ-015 On accepted BUS_LOAD, owner table entry [response] SHALL be set valid with owner (ICACHE/DCACHE) at next edge.
REQ-016 Accepted BUS_STORE SHALL NOT allocate an owner entry.
REQ-017 mem2proc_tag != 0 with valid entry SHALL assert owner's data_valid same cycle, with data_tag=mem2proc_tag, data=mem2proc_data; entry cleared at next edge.
REQ-018 Non-owner data_valid SHALL be 0; data/data_tag of a non-valid port SHALL be 0.
REQ-019 mem2proc_tag != 0 with no valid entry SHALL assert stray_tag for that cycle and route nothing.
REQ-020 Same tag returned and re-allocated in one cycle: allocation SHALL win (entry valid with new owner).
REQ-021 Allocation to an already-valid tag SHALL overwrite the owner (memory guarantees uniqueness; no error).
REQ-022 Tag 0 SHALL never be allocated or routed.

Reset
REQ-023 While reset==0: owner table all invalid, starve_cnt=0, proc2mem_command=BUS_NONE, all grants, data_valid, stray_tag = 0.
REQ-024 Reset mid-transaction SHALL discard all outstanding ownership; later returns of those tags assert stray_tag.
REQ-025 First request SHALL be acceptable in the first cycle after reset deasserts.

Structure
REQ-026 BUS_COMMAND, MEM_TAG (4-bit) and owner enum (ICACHE, DCACHE) SHALL live in the shared sys_defs package; STARVE_LIMIT stays a module parameter.
REQ-027 Owner table SHALL be a sub-module mem_tag_table (15 entries, valid+owner, one alloc port, one free port, alloc-wins).
REQ-028 Arbitration and starvation logic SHALL stay in mem_arbiter.

Verification
REQ-029 Single icache load addr 0x100, response 3; tag 3 returns later with data 0xDEAD -> icache_grant=1, icache_resp_tag=3, then icache_data_valid=1, data 0xDEAD, dcache_data_valid=0.
REQ-030 Both request every cycle, response always nonzero, STARVE_LIMIT=4 -> dcache granted 4 cycles, icache 5th, pattern repeats.
REQ-031 dcache BUS_STORE addr 0x200 data 0x55, response 5; then mem2proc_tag=5 -> grant=1, no data_valid, stray_tag=1.
REQ-032 mem2proc_response=0 for 3 cycles with both requesting -> no grants, starve_cnt unchanged, command still driven.
REQ-033 Tag 7 returns and is re-allocated to dcache same cycle -> icache_data_valid=1 for old data; entry 7 then owned by dcache.
REQ-034 Two icache loads outstanding (tags 1,2), reset pulsed low mid-cycle -> outputs zero immediately; later tag 1 return gives stray_tag=1, no data_valid.
